// File: rtl/alu_pipe.sv
// alu_pipe: two-stage execute/writeback datapath core.
// Stage X holds the accepted instruction and evaluates the ALU against
// forwarded operands; stage W holds the registered result and commits it
// to the register file on the output handshake.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4+3*AW-1:0]   in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_we,
  output logic [AW-1:0]       out_addr,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_carry,
  input  logic [AW-1:0]       dbg_addr,
  output logic [WIDTH-1:0]    dbg_data
);

  localparam int NREGS = 2**AW;
  localparam int IW    = 4 + 3*AW;

  // Register file and pipeline state
  logic [WIDTH-1:0] regs_r [NREGS];
  logic             x_valid_r;
  logic [IW-1:0]    x_instr_r;
  logic             w_valid_r;
  logic             w_we_r;
  logic [AW-1:0]    w_addr_r;
  logic [WIDTH-1:0] w_data_r;
  logic             w_carry_r;

  // Decoded X fields and ALU results
  logic [3:0]       x_op_s;
  logic [AW-1:0]    x_rd_s;
  logic [AW-1:0]    x_rs1_s;
  logic [AW-1:0]    x_rs2_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             we_s;
  logic             x_adv_s;
  logic             accept_s;
  logic             retire_s;
  logic             commit_s;

  assign x_op_s  = x_instr_r[IW-1 -: 4];
  assign x_rd_s  = x_instr_r[3*AW-1 -: AW];
  assign x_rs1_s = x_instr_r[2*AW-1 -: AW];
  assign x_rs2_s = x_instr_r[AW-1:0];

  // X moves into W whenever W is free or is retiring this cycle; a held W
  // (valid, consumer not ready) freezes both stages.
  assign x_adv_s  = x_valid_r && (!w_valid_r || out_ready);
  assign in_ready = !x_valid_r || x_adv_s;
  assign accept_s = in_valid && in_ready;
  assign retire_s = w_valid_r && out_ready;
  assign commit_s = retire_s && w_we_r;

  assign out_valid = w_valid_r;
  assign out_we    = w_we_r;
  assign out_addr  = w_addr_r;
  assign out_data  = w_data_r;
  assign out_carry = w_carry_r;

  // Debug port sees the architectural file only, never the W result.
  assign dbg_data = regs_r[dbg_addr];

  // Operand fetch with forwarding from a writing W stage (no-ops never forward)
  always_comb begin
    a_s   = regs_r[x_rs1_s];
    b_s   = regs_r[x_rs2_s];
    imm_s = WIDTH'(x_rs2_s);
    if (w_valid_r && w_we_r && (w_addr_r == x_rs1_s)) begin
      a_s = w_data_r;
    end else begin
      a_s = regs_r[x_rs1_s];
    end
    if (w_valid_r && w_we_r && (w_addr_r == x_rs2_s)) begin
      b_s = w_data_r;
    end else begin
      b_s = regs_r[x_rs2_s];
    end
  end

  // ALU: the extra top bit of add/sub results is carry resp. borrow.
  // Shifts by an amount >= WIDTH yield zero by SV shift semantics.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    we_s    = 1'b1;
    case (x_op_s)
      4'd0:  {carry_s, res_s} = {1'b0, a_s} + {1'b0, b_s};
      4'd1:  {carry_s, res_s} = {1'b0, a_s} - {1'b0, b_s};
      4'd2:  res_s = (a_s < b_s) ? WIDTH'(1'b1) : {WIDTH{1'b0}};
      4'd3:  res_s = a_s & b_s;
      4'd4:  res_s = a_s | b_s;
      4'd5:  res_s = a_s ^ b_s;
      4'd6:  res_s = a_s & imm_s;
      4'd7:  res_s = a_s | imm_s;
      4'd8:  res_s = a_s ^ imm_s;
      4'd9:  {carry_s, res_s} = {1'b0, a_s} + {1'b0, imm_s};
      4'd10: {carry_s, res_s} = {1'b0, a_s} - {1'b0, imm_s};
      4'd11: res_s = a_s << x_rs2_s;
      4'd12: res_s = a_s >> x_rs2_s;
      4'd13: res_s = WIDTH'({x_rs1_s, x_rs2_s});
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // Stage X: capture on accept, empty when advancing without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid_r <= 1'b0;
      x_instr_r <= {IW{1'b0}};
    end else if (accept_s) begin
      x_valid_r <= 1'b1;
      x_instr_r <= in_instr;
    end else if (x_adv_s) begin
      x_valid_r <= 1'b0;
    end
  end

  // Stage W: load from X, otherwise clear after the retiring handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_r <= 1'b0;
      w_we_r    <= 1'b0;
      w_addr_r  <= {AW{1'b0}};
      w_data_r  <= {WIDTH{1'b0}};
      w_carry_r <= 1'b0;
    end else if (x_adv_s) begin
      w_valid_r <= 1'b1;
      w_we_r    <= we_s;
      w_addr_r  <= x_rd_s;
      w_data_r  <= res_s;
      w_carry_r <= carry_s;
    end else if (retire_s) begin
      w_valid_r <= 1'b0;
      w_we_r    <= 1'b0;
      w_addr_r  <= {AW{1'b0}};
      w_data_r  <= {WIDTH{1'b0}};
      w_carry_r <= 1'b0;
    end
  end

  // Register file: cleared by reset, written only at the retire handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      regs_r[w_addr_r] <= w_data_r;
    end
  end

endmodule
